// File: rtl/intm_ds_queue_if.sv
// Shared uop types plus the CDB snoop and dispatch-to-RS interfaces
// used by the integer mul/div dispatch queue.
package intm_dsq_pkg;
   localparam int ID_WIDTH  = 2;
   localparam int CDB_WIDTH = 2;
   localparam int PHY_W     = 6;

   typedef struct packed {
      logic [PHY_W-1:0] rd_phy;
      logic [PHY_W-1:0] rs1_phy;
      logic             rs1_valid;
      logic [PHY_W-1:0] rs2_phy;
      logic             rs2_valid;
      logic [7:0]       op;
   } uop_t;
endpackage

interface cdb_itf #(
   parameter int CDB_WIDTH = intm_dsq_pkg::CDB_WIDTH
);
   import intm_dsq_pkg::*;
   logic [CDB_WIDTH-1:0]            valid;
   logic [CDB_WIDTH-1:0][PHY_W-1:0] rd_phy;
   modport src (output valid, rd_phy);
   modport rs  (input  valid, rd_phy);
endinterface

interface ds_rs_itf #(
   parameter int ID_WIDTH = intm_dsq_pkg::ID_WIDTH
);
   import intm_dsq_pkg::*;
   logic [ID_WIDTH-1:0] valid;
   uop_t [ID_WIDTH-1:0] uop;
   logic                ready;
   modport ds (output valid, uop, input ready);
   modport rs (input valid, uop, output ready);
endinterface

// File: rtl/intm_ds_queue.sv
// In-order dispatch queue between rename and the int mul/div RS.
// Optional same-cycle bypass when empty: define INTM_DSQ_BYPASS_EN.
module intm_ds_queue
   import intm_dsq_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int ID_WIDTH  = intm_dsq_pkg::ID_WIDTH,
   parameter int CDB_WIDTH = intm_dsq_pkg::CDB_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [ID_WIDTH-1:0]       in_valid,
   input  uop_t [ID_WIDTH-1:0]       in_uop,
   output logic                      in_ready,
   cdb_itf.rs                        cdb,
   ds_rs_itf.ds                      to_rs,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   uop_t          mem_q [DEPTH];
   uop_t          mem_d [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;

   logic [CW-1:0] n_pres, n_in, n_enq, n_deq, room;
   logic          enq, deq, byp;
   logic [ID_WIDTH-1:0] pres_v;
   uop_t [ID_WIDTH-1:0] pres_u;

   // Set source-ready bits for any CDB tag matching this uop
   function automatic uop_t wake(
      input uop_t                            u,
      input logic [CDB_WIDTH-1:0]            v,
      input logic [CDB_WIDTH-1:0][PHY_W-1:0] p
   );
      uop_t r;
      r = u;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         if (v[k] && p[k] == u.rs1_phy) r.rs1_valid = 1'b1;
         if (v[k] && p[k] == u.rs2_phy) r.rs2_valid = 1'b1;
      end
      return r;
   endfunction

`ifdef INTM_DSQ_BYPASS_EN
   assign byp = (count_q == '0) && to_rs.ready && !flush;
`else
   assign byp = 1'b0;
`endif

   // Occupancy, handshake and pointer-advance amounts
   always_comb begin
      n_pres = (count_q < CW'(ID_WIDTH)) ? count_q : CW'(ID_WIDTH);
      n_in   = '0;
      for (int i = 0; i < ID_WIDTH; i++)
         n_in = n_in + CW'(in_valid[i]);
      room     = CW'(DEPTH) - count_q;
`ifdef INTM_DSQ_BYPASS_EN
      in_ready = ((room >= CW'(ID_WIDTH)) ||
                  (count_q == '0 && to_rs.ready)) && !flush;
`else
      in_ready = (room >= CW'(ID_WIDTH)) && !flush;
`endif
      enq   = in_ready && (|in_valid) && !byp;
      n_enq = enq ? n_in : '0;
      deq   = to_rs.ready && (|pres_v) && !byp;
      n_deq = deq ? n_pres : '0;
   end

   // Oldest group (or bypassed incoming lanes) presented to the RS
   always_comb begin
      pres_v = '0;
      pres_u = '0;
      if (byp) begin
         int j;
         j = 0;
         for (int i = 0; i < ID_WIDTH; i++) begin
            if (in_valid[i]) begin
               pres_v[j] = 1'b1;
               pres_u[j] = wake(in_uop[i], cdb.valid, cdb.rd_phy);
               j = j + 1;
            end
         end
      end else begin
         for (int w = 0; w < ID_WIDTH; w++) begin
            pres_v[w] = (CW'(w) < n_pres) && !flush;
            pres_u[w] = wake(mem_q[head_q + PW'(w)],
                             cdb.valid, cdb.rd_phy);
         end
      end
   end

   assign to_rs.valid = pres_v;
   assign to_rs.uop   = pres_u;
   assign count       = count_q;

   // Next storage image: snoop every entry, then compact-write new lanes
   always_comb begin
      logic [PW-1:0] slot;
      for (int e = 0; e < DEPTH; e++)
         mem_d[e] = wake(mem_q[e], cdb.valid, cdb.rd_phy);
      slot = tail_q;
      for (int i = 0; i < ID_WIDTH; i++) begin
         if (enq && in_valid[i]) begin
            mem_d[slot] = wake(in_uop[i], cdb.valid, cdb.rd_phy);
            slot = slot + 1'b1;
         end
      end
   end

   // Storage, pointers and occupancy; flush beats enqueue/dequeue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            head_q  <= head_q + PW'(n_deq);
            tail_q  <= tail_q + PW'(n_enq);
            count_q <= count_q + n_enq - n_deq;
         end
      end
   end
endmodule
